check_nodes_serial: RTL

//  Even-layer (check-node) update of the min-sum LDPC decoder; the counterpart of the variable-node layer.

---
 rtl/ldpc_pkg.sv | 16 +
 rtl/check_nodes_serial_if.sv | 43 ++++
 rtl/cn_min_tracker.sv | 42 ++++
 rtl/check_nodes_serial.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and constants for the min-sum LDPC check-node layer.
// Default code geometry: 44 variable nodes, 12 check nodes, 147 edges,
// 8-bit two's-complement messages, 5-bit degree fields.
package ldpc_pkg;
  localparam int N_V       = 44;
  localparam int MSG_W     = 8;
  localparam int DEG_WIDTH = 5;

  // Largest representable message magnitude, 2^(W-1)-1.
  localparam logic [MSG_W-2:0] MSG_MAX = {(MSG_W-1){1'b1}};

  typedef logic signed [MSG_W-1:0] msg_t;
  typedef logic [DEG_WIDTH-1:0]    deg_t;

  typedef enum logic [2:0] {IDLE, INIT, SCAN, WRITE, NEXT, DONE} cn_state_e;
endpackage

// File: rtl/check_nodes_serial_if.sv
// Bus bundle for check_nodes_serial.
//   start   : begin one check-layer pass
//   chk_deg : per-check degree, check-major edge order
//   in_msg  : variable-to-check messages (held stable while busy)
//   beta    : per-edge unsigned offset (only with CN_OFFSET_EN)
//   busy    : pass in progress
//   done    : one-cycle completion pulse
//   out_msg : registered check-to-variable messages
// master drives the request side, slave is the check-node engine.
interface check_nodes_serial_if
  import ldpc_pkg::*;
#(
  parameter int N_C   = 12,
  parameter int E     = 147,
  parameter int W     = MSG_W,
  parameter int DEG_W = DEG_WIDTH
);
  logic                      start;
  logic [N_C-1:0][DEG_W-1:0] chk_deg;
  logic [E-1:0][W-1:0]       in_msg;
`ifdef CN_OFFSET_EN
  logic [E-1:0][W-1:0]       beta;
`endif
  logic                      busy;
  logic                      done;
  logic [E-1:0][W-1:0]       out_msg;

  modport master (
    output start, chk_deg, in_msg,
`ifdef CN_OFFSET_EN
    output beta,
`endif
    input  busy, done, out_msg
  );

  modport slave (
    input  start, chk_deg, in_msg,
`ifdef CN_OFFSET_EN
    input  beta,
`endif
    output busy, done, out_msg
  );
endinterface

// File: rtl/cn_min_tracker.sv
// Running two-minimum tracker for one check node.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart tracking (min1=min2=max, idx1=0, parity=0)
//   upd      : fold in one edge (mag, sgn) observed at position k
//   min1/min2: smallest and second-smallest magnitudes seen
//   idx1     : position of min1
//   parity   : XOR of all folded signs
// A magnitude equal to min1 lands in min2, so ties leave min2 == min1.
module cn_min_tracker #(
  parameter int W     = 8,
  parameter int DEG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             upd,
  input  logic [W-2:0]     mag,
  input  logic             sgn,
  input  logic [DEG_W-1:0] k,
  output logic [W-2:0]     min1,
  output logic [W-2:0]     min2,
  output logic [DEG_W-1:0] idx1,
  output logic             parity
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      min1   <= '1;
      min2   <= '1;
      idx1   <= '0;
      parity <= 1'b0;
    end else if (upd) begin
      parity <= parity ^ sgn;
      if (mag < min1) begin
        min2 <= min1;
        min1 <= mag;
        idx1 <= k;
      end else if (mag < min2) begin
        min2 <= mag;
      end
    end
  end
endmodule

// File: rtl/check_nodes_serial.sv
// Serial min-sum check-node layer: one check node at a time, one edge per
// cycle. Each check is scanned once to collect min1/min2/parity, then its
// edges are written with the extrinsic min and sign.
//   clk, rst : clock, synchronous active-high reset
//   bus      : check_nodes_serial_if slave (start/chk_deg/in_msg[/beta] in,
//              busy/done/out_msg out)
// Build option CN_OFFSET_EN: offset min-sum, written magnitude becomes
// max(m - beta[e], 0). Without it the plain minimum is written.
module check_nodes_serial
  import ldpc_pkg::*;
#(
  parameter int N_C   = 12,
  parameter int E     = 147,
  parameter int W     = MSG_W,
  parameter int DEG_W = DEG_WIDTH
) (
  input logic clk,
  input logic rst,
  check_nodes_serial_if.slave bus
);
  localparam int CW  = (N_C > 1) ? $clog2(N_C) : 1;
  localparam int EIW = (E > 1) ? $clog2(E) : 1;
  // Wide enough for any degree sum, so out-of-range edges are detectable.
  localparam int BW  = $clog2(N_C * (2 ** DEG_W) + E) + 1;

  cn_state_e state, state_n;
  logic [CW-1:0]       c;
  logic [DEG_W-1:0]    k, deg, idx1;
  logic [BW-1:0]       base, e;
  logic [EIW-1:0]      ei;
  logic                in_range, last, clr, upd, wr, sgn, parity;
  logic signed [W-1:0] msg, neg_msg, val;
  logic [W-2:0]        mag, m, mo, min1, min2;

  assign deg      = bus.chk_deg[c];
  assign e        = base + BW'(k);
  assign in_range = (e < BW'(E));
  assign ei       = in_range ? e[EIW-1:0] : '0;
  assign msg      = in_range ? $signed(bus.in_msg[ei]) : '0;
  assign sgn      = msg[W-1];
  assign neg_msg  = -msg;
  // -2^(W-1) has no positive counterpart; clamp it instead of wrapping.
  assign mag      = (msg == {1'b1, {(W-1){1'b0}}}) ? '1 :
                    sgn ? neg_msg[W-2:0] : msg[W-2:0];
  assign last     = (k == deg - 1'b1);

  cn_min_tracker #(.W(W), .DEG_W(DEG_W)) u_trk (
    .clk(clk), .rst(rst), .clr(clr), .upd(upd), .mag(mag), .sgn(sgn),
    .k(k), .min1(min1), .min2(min2), .idx1(idx1), .parity(parity)
  );

  // Extrinsic magnitude: the edge holding min1 gets min2, all others min1.
  assign m = (k == idx1) ? min2 : min1;

`ifdef CN_OFFSET_EN
  logic [W-1:0] m_ext, diff;
  assign m_ext = {1'b0, m};
  assign diff  = m_ext - bus.beta[ei];
  assign mo    = (m_ext > bus.beta[ei]) ? diff[W-2:0] : '0;
`else
  assign mo = m;
`endif

  // parity ^ own sign = product of the other edges' signs.
  assign val = (parity ^ sgn) ? -$signed({1'b0, mo}) : $signed({1'b0, mo});

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    upd     = 1'b0;
    wr      = 1'b0;
    unique case (state)
      IDLE:  if (bus.start) state_n = INIT;
      INIT:  begin
        clr     = 1'b1;
        state_n = (deg != '0) ? SCAN : NEXT;
      end
      SCAN:  begin
        upd = 1'b1;
        if (last) state_n = WRITE;
      end
      WRITE: begin
        wr = 1'b1;
        if (last) state_n = NEXT;
      end
      NEXT:  state_n = (c == CW'(N_C - 1)) ? DONE : INIT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      k     <= '0;
      base  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          c    <= '0;
          k    <= '0;
          base <= '0;
        end
        INIT:        k <= '0;
        SCAN, WRITE: k <= last ? '0 : k + 1'b1;
        NEXT: begin
          base <= base + BW'(deg);
          c    <= (c == CW'(N_C - 1)) ? '0 : c + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   bus.out_msg     <= '0;
    else if (wr && in_range)   bus.out_msg[ei] <= val;
  end

  assign bus.busy = (state != IDLE) && (state != DONE);
  assign bus.done = (state == DONE);
endmodule
